pipe_pe_ui_addsub: RTL

//  Next-generation TyTra pipeline PE for unsigned integer add/subtract, multi-lane, runtime mode.

---
 rtl/pipe_pe_ui_addsub.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pipe_pe_ui_addsub.sv
// rtl/pipe_pe_ui_addsub.sv - elastic multi-lane unsigned add/subtract pipeline PE
// Stage 0 captures {mode,in1,in2}; the arithmetic sits between stage 0 and
// stage 1, later stages only delay the result. With STAGES=1 the result is
// driven combinationally from the stage-0 registers.
module pipe_pe_ui_addsub #(
    parameter int N      = 64,
    parameter int LANES  = 1,
    parameter int STAGES = 2,
    parameter int SAT    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trigger,
    output logic                 cts,
    input  logic                 mode,
    input  logic [LANES*N-1:0]   in1,
    input  logic [LANES*N-1:0]   in2,
    output logic [LANES*N-1:0]   out,
    output logic [LANES-1:0]     ovf,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [STAGES-1:0]  v;
    logic [STAGES-1:0]  vprev;
    logic [STAGES-1:0]  adv;
    logic               mode_q;
    logic [LANES*N-1:0] a_q;
    logic [LANES*N-1:0] b_q;
    logic [LANES*N-1:0] res_c;
    logic [LANES-1:0]   ovf_c;

    // A stage may advance when it is empty or when every stage after it can
    // advance; expressed as "some stage from here down is empty" to keep the
    // chain free of a combinational self-reference.
    always_comb begin
        logic full;
        adv  = '0;
        full = 1'b1;
        for (int i = 0; i < STAGES; i++) begin
            full = 1'b1;
            for (int j = i; j < STAGES; j++) begin
                full = full & v[j];
            end
            adv[i] = out_ready | ~full;
        end
    end

    // Valid bit feeding each stage: the input handshake for stage 0.
    always_comb begin
        vprev    = '0;
        vprev[0] = trigger;
        for (int i = 1; i < STAGES; i++) begin
            vprev[i] = v[i-1];
        end
    end

    assign cts       = adv[0];
    assign out_valid = v[STAGES-1];

    // Valid bits move forward on advance and hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (adv[i]) begin
                    v[i] <= vprev[i];
                end
            end
        end
    end

    // Stage 0 operand capture; only an accepted transaction overwrites it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
        end else if (adv[0] && trigger) begin
            mode_q <= mode;
            a_q    <= in1;
            b_q    <= in2;
        end
    end

    // Per-lane N+1 bit add/subtract with optional saturation on carry/borrow.
    always_comb begin
        logic [N:0]   sum;
        logic [N:0]   dif;
        logic [N-1:0] r;
        logic         c;
        res_c = '0;
        ovf_c = '0;
        sum   = '0;
        dif   = '0;
        r     = '0;
        c     = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            sum = {1'b0, a_q[k*N +: N]} + {1'b0, b_q[k*N +: N]};
            dif = {1'b0, a_q[k*N +: N]} - {1'b0, b_q[k*N +: N]};
            r   = mode_q ? dif[N-1:0] : sum[N-1:0];
            c   = mode_q ? dif[N] : sum[N];
            if (SAT != 0 && c) begin
                r = mode_q ? '0 : '1;
            end
            res_c[k*N +: N] = r;
            ovf_c[k]        = c;
        end
    end

    if (STAGES > 1) begin : g_pipe
        logic [LANES*N-1:0] res_q [1:STAGES-1];
        logic [LANES-1:0]   ovf_q [1:STAGES-1];

        // Result stages: stage 1 takes the arithmetic, later ones shift.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 1; k < STAGES; k++) begin
                    res_q[k] <= '0;
                    ovf_q[k] <= '0;
                end
            end else begin
                if (adv[1] && v[0]) begin
                    res_q[1] <= res_c;
                    ovf_q[1] <= ovf_c;
                end
                for (int k = 2; k < STAGES; k++) begin
                    if (adv[k] && v[k-1]) begin
                        res_q[k] <= res_q[k-1];
                        ovf_q[k] <= ovf_q[k-1];
                    end
                end
            end
        end

        assign out = res_q[STAGES-1];
        assign ovf = ovf_q[STAGES-1];
    end else begin : g_comb
        assign out = res_c;
        assign ovf = ovf_c;
    end

endmodule
